// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - two-requester arbiter sharing one combinational barrel shifter
module shifter_arbiter #(
  parameter int DATA_W     = 32,
  parameter int NUM_W      = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [NUM_W-1:0]  req0_num,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [NUM_W-1:0]  req1_num,
  input  logic              req1_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic [2:0]        SHFT_OP,
  output logic [DATA_W-1:0] Shift_Data,
  output logic [NUM_W-1:0]  Shift_Num,
  output logic              Carry_flag,
  input  logic [DATA_W-1:0] Shift_Out,
  input  logic              Shift_Carry_Out,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [NUM_W-1:0]  snum_q, snum_d;
  logic              cin_q, cin_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rcarry_q, rcarry_d;
  logic              gnt0, gnt1;

  // Pick at most one winner, and only while idle; the pointer breaks ties in round-robin mode
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && !req1_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid && !req0_valid) begin
        gnt1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
        if ((FIXED_PRIO != 0) || !ptr_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
    end
  end

  // Next-state logic: latch winner operands, capture shifter result, release on response handshake
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    sdata_d  = sdata_q;
    snum_d   = snum_q;
    cin_d    = cin_q;
    id_d     = id_q;
    rdata_d  = rdata_q;
    rcarry_d = rcarry_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0) begin
          op_d    = req0_op;
          sdata_d = req0_data;
          snum_d  = req0_num;
          cin_d   = req0_cin;
          id_d    = 1'b0;
          state_d = ST_SHIFT;
        end else if (gnt1) begin
          op_d    = req1_op;
          sdata_d = req1_data;
          snum_d  = req1_num;
          cin_d   = req1_cin;
          id_d    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rdata_d  = Shift_Out;
        rcarry_d = Shift_Carry_Out;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          // Hand the tie-break to whichever requester lost this round
          ptr_d   = ~id_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      op_q     <= '0;
      sdata_q  <= '0;
      snum_q   <= '0;
      cin_q    <= 1'b0;
      id_q     <= 1'b0;
      rdata_q  <= '0;
      rcarry_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      sdata_q  <= sdata_d;
      snum_q   <= snum_d;
      cin_q    <= cin_d;
      id_q     <= id_d;
      rdata_q  <= rdata_d;
      rcarry_q <= rcarry_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = rdata_q;
  assign rsp_carry  = rcarry_q;
  assign SHFT_OP    = op_q;
  assign Shift_Data = sdata_q;
  assign Shift_Num  = snum_q;
  assign Carry_flag = cin_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - self-checking bench for shifter_arbiter (round-robin and fixed-priority instances)
module tb_shifter_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req1_valid, req0_cin, req1_cin, rsp_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_data, req1_data;
  logic [7:0]  req0_num, req1_num;

  logic        r0_rdy_a, r1_rdy_a, rv_a, rid_a, rcar_a, cf_a, sco_a, busy_a;
  logic [31:0] rdata_a, sd_a, so_a;
  logic [2:0]  op_a;
  logic [7:0]  sn_a;
  logic        r0_rdy_b, r1_rdy_b, rv_b, rid_b, rcar_b, cf_b, sco_b, busy_b;
  logic [31:0] rdata_b, sd_b, so_b;
  logic [2:0]  op_b;
  logic [7:0]  sn_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stub shifters
  assign so_a  = sd_a ^ {24'h0, sn_a};
  assign sco_a = cf_a;
  assign so_b  = sd_b ^ {24'h0, sn_b};
  assign sco_b = cf_b;

  shifter_arbiter #(.DATA_W(32), .NUM_W(8), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_rdy_a), .req0_op(req0_op), .req0_data(req0_data),
    .req0_num(req0_num), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(r1_rdy_a), .req1_op(req1_op), .req1_data(req1_data),
    .req1_num(req1_num), .req1_cin(req1_cin),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_id(rid_a), .rsp_data(rdata_a), .rsp_carry(rcar_a),
    .SHFT_OP(op_a), .Shift_Data(sd_a), .Shift_Num(sn_a), .Carry_flag(cf_a),
    .Shift_Out(so_a), .Shift_Carry_Out(sco_a), .busy(busy_a)
  );

  shifter_arbiter #(.DATA_W(32), .NUM_W(8), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_rdy_b), .req0_op(req0_op), .req0_data(req0_data),
    .req0_num(req0_num), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(r1_rdy_b), .req1_op(req1_op), .req1_data(req1_data),
    .req1_num(req1_num), .req1_cin(req1_cin),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_id(rid_b), .rsp_data(rdata_b), .rsp_carry(rcar_b),
    .SHFT_OP(op_b), .Shift_Data(sd_b), .Shift_Num(sn_b), .Carry_flag(cf_b),
    .Shift_Out(so_b), .Shift_Carry_Out(sco_b), .busy(busy_b)
  );

  function automatic logic [31:0] res(input logic [31:0] d, input logic [7:0] n);
    return d ^ {24'h0, n};
  endfunction

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_op = 3'b0; req0_data = '0; req0_num = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_op = 3'b0; req1_data = '0; req1_num = '0; req1_cin = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  // Returns at a falling edge with reset released
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rv_a, busy_a, rid_a, rcar_a} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {rv_a, busy_a, rid_a, rcar_a});
    end
    checks++;
    if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rdata_a); end
    checks++;
    if ({op_a, sd_a, sn_a, cf_a} !== 44'h0) begin
      errors++; $display("FAIL reset_shifter_side got=%h exp=0", {op_a, sd_a, sn_a, cf_a});
    end
    checks++;
    if ({r0_rdy_a, r1_rdy_a, rv_b, busy_b} !== 4'b0) begin
      errors++; $display("FAIL reset_idle_ready got=%b exp=0000", {r0_rdy_a, r1_rdy_a, rv_b, busy_b});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b000; req0_data = 32'haaaaff00; req0_num = 8'h04; req0_cin = 1'b0;
    #1;
    checks++;
    if ({r1_rdy_a, r0_rdy_a} !== 2'b01) begin
      errors++; $display("FAIL single_grant got=%b exp=01", {r1_rdy_a, r0_rdy_a});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({r0_rdy_a, rv_a, busy_a} !== 3'b001) begin
      errors++; $display("FAIL single_shift_phase got=%b exp=001", {r0_rdy_a, rv_a, busy_a});
    end
    checks++;
    if ({op_a, sn_a, sd_a} !== {3'b000, 8'h04, 32'haaaaff00}) begin
      errors++; $display("FAIL single_shifter_in got=%h exp=%h", {op_a, sn_a, sd_a}, {3'b000, 8'h04, 32'haaaaff00});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rv_a, rid_a, rcar_a, rdata_a} !== {1'b1, 1'b0, 1'b0, 32'haaaaff04}) begin
      errors++; $display("FAIL single_rsp got=%b/%b/%b/%h exp=1/0/0/aaaaff04", rv_a, rid_a, rcar_a, rdata_a);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if ({busy_a, rv_a} !== 2'b00) begin
      errors++; $display("FAIL single_back_idle got=%b exp=00", {busy_a, rv_a});
    end
  endtask

  task automatic test_round_robin();
    int ngnt, nrsp, last;
    logic        exp_id;
    logic [31:0] exp_d;
    ngnt = 0; nrsp = 0; last = -1;
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b001; req0_data = 32'haaaaff00; req0_num = 8'h01; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b010; req1_data = 32'haaaaff00; req1_num = 8'h10; req1_cin = 1'b1;
    rsp_ready  = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (r0_rdy_a || r1_rdy_a) begin
        checks++;
        if ({r1_rdy_a, r0_rdy_a} !== ((ngnt % 2) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_grant_order n=%0d got=%b exp=%b", ngnt, {r1_rdy_a, r0_rdy_a},
                             ((ngnt % 2) ? 2'b10 : 2'b01));
        end
        ngnt++;
      end
      if (rv_a) begin
        exp_id = ((nrsp % 2) != 0);
        exp_d  = exp_id ? 32'haaaaff10 : 32'haaaaff01;
        checks++;
        if ({rid_a, rcar_a, rdata_a} !== {exp_id, exp_id, exp_d}) begin
          errors++; $display("FAIL rr_rsp n=%0d got=%b/%b/%h exp=%b/%b/%h", nrsp, rid_a, rcar_a, rdata_a,
                             exp_id, exp_id, exp_d);
        end
        if (nrsp > 0) begin
          checks++;
          if (c - last != 3) begin errors++; $display("FAIL rr_spacing got=%0d exp=3", c - last); end
        end
        last = c;
        nrsp++;
      end
      checks++;
      if (r1_rdy_b !== 1'b0 || (rv_b && {rid_b, rdata_b} !== {1'b0, 32'haaaaff01})) begin
        errors++; $display("FAIL fixed_prio_only_req0 got=%b/%b/%h exp=0/0/aaaaff01", r1_rdy_b, rid_b, rdata_b);
      end
      @(negedge clk);
    end
    checks++;
    if (ngnt != 5 || nrsp != 4) begin
      errors++; $display("FAIL rr_counts got=%0d/%0d exp=5/4", ngnt, nrsp);
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    logic [31:0] d0;
    logic [7:0]  n0;
    d0 = $urandom; n0 = 8'($urandom);
    do_reset();
    req0_valid = 1'b1; req0_data = d0; req0_num = n0; req0_cin = 1'b1; req0_op = 3'b101;
    req1_valid = 1'b1; req1_data = $urandom; req1_num = 8'($urandom);
    #1;
    checks++;
    if ({r1_rdy_a, r0_rdy_a} !== 2'b01) begin errors++; $display("FAIL stall_first_grant got=%b exp=01", {r1_rdy_a, r0_rdy_a}); end
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({rv_a, busy_a, rid_a, rcar_a, rdata_a, r0_rdy_a, r1_rdy_a} !== {4'b1101, res(d0, n0), 2'b00}) begin
        errors++; $display("FAIL stall_hold c=%0d got=%b/%h/%b%b exp=1101/%h/00", c, {rv_a, busy_a, rid_a, rcar_a},
                           rdata_a, r0_rdy_a, r1_rdy_a, res(d0, n0));
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rv_a !== 1'b1) begin errors++; $display("FAIL stall_release_valid got=%b exp=1", rv_a); end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if ({busy_a, r1_rdy_a, r0_rdy_a} !== 3'b010) begin
      errors++; $display("FAIL stall_next_grant_req1 got=%b exp=010", {busy_a, r1_rdy_a, r0_rdy_a});
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = $urandom; req0_num = 8'($urandom);
    #1;
    checks++;
    if (r0_rdy_a !== 1'b1) begin errors++; $display("FAIL mid_pre_grant0 got=%b exp=1", r0_rdy_a); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req1_valid = 1'b1; req1_data = $urandom; req1_num = 8'($urandom); req1_cin = 1'b1; req1_op = 3'b111;
    #1;
    checks++;
    if (r1_rdy_a !== 1'b1) begin errors++; $display("FAIL mid_grant1 got=%b exp=1", r1_rdy_a); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++;
    if ({busy_a, rv_a, rid_a} !== 3'b101) begin errors++; $display("FAIL mid_in_shift got=%b exp=101", {busy_a, rv_a, rid_a}); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rv_a, busy_a, rid_a, rcar_a, rdata_a, op_a, sd_a, sn_a, cf_a} !== 80'h0) begin
      errors++; $display("FAIL mid_async_clear got=%h exp=0", {rv_a, busy_a, rid_a, rcar_a, rdata_a, op_a, sd_a, sn_a, cf_a});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({rv_a, busy_a} !== 2'b00) begin errors++; $display("FAIL mid_no_late_rsp got=%b exp=00", {rv_a, busy_a}); end
      @(negedge clk);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({r1_rdy_a, r0_rdy_a} !== 2'b01) begin errors++; $display("FAIL mid_ptr_reset got=%b exp=01", {r1_rdy_a, r0_rdy_a}); end
    clear_inputs();
  endtask

  task automatic test_drop();
    int nrsp;
    logic [31:0] d0;
    logic [7:0]  n0;
    nrsp = 0; d0 = $urandom; n0 = 8'($urandom);
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = d0; req0_num = n0;
    req1_valid = 1'b1; req1_data = $urandom; req1_num = 8'($urandom);
    #1;
    checks++;
    if ({r1_rdy_a, r0_rdy_a} !== 2'b01) begin errors++; $display("FAIL drop_grant got=%b exp=01", {r1_rdy_a, r0_rdy_a}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (r1_rdy_a !== 1'b0) begin errors++; $display("FAIL drop_req1_granted got=%b exp=0", r1_rdy_a); end
      if (rv_a) begin
        nrsp++;
        checks++;
        if ({rid_a, rdata_a} !== {1'b0, res(d0, n0)}) begin
          errors++; $display("FAIL drop_rsp got=%b/%h exp=0/%h", rid_a, rdata_a, res(d0, n0));
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (nrsp != 1 || busy_a !== 1'b0) begin errors++; $display("FAIL drop_rsp_count got=%0d/%b exp=1/0", nrsp, busy_a); end
    clear_inputs();
  endtask

  // Randomized traffic against a transaction-level model of the round-robin instance
  task automatic test_random();
    bit          m_busy, m_in_resp, m_id, m_carry, m_pref, g0, g1, acc0, acc1;
    logic [31:0] m_data;
    m_busy = 0; m_in_resp = 0; m_id = 0; m_carry = 0; m_pref = 0; acc0 = 0; acc1 = 0; m_data = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid) begin
        if ($urandom_range(2) == 0) begin
          req0_valid = 1'b1; req0_op = 3'($urandom); req0_data = $urandom; req0_num = 8'($urandom); req0_cin = 1'($urandom);
        end
      end else if ($urandom_range(7) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid) begin
        if ($urandom_range(2) == 0) begin
          req1_valid = 1'b1; req1_op = 3'($urandom); req1_data = $urandom; req1_num = 8'($urandom); req1_cin = 1'($urandom);
        end
      end else if ($urandom_range(7) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = 1'($urandom);
      #1;
      g0 = 0; g1 = 0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          g0 = !m_pref; g1 = m_pref;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      checks++;
      if ({r1_rdy_a, r0_rdy_a, rv_a, busy_a} !== {g1, g0, m_in_resp, m_busy}) begin
        errors++; $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c, {r1_rdy_a, r0_rdy_a, rv_a, busy_a}, {g1, g0, m_in_resp, m_busy});
      end
      if (m_in_resp) begin
        checks++;
        if ({rid_a, rcar_a, rdata_a} !== {m_id, m_carry, m_data}) begin
          errors++; $display("FAIL rand_rsp c=%0d got=%b/%b/%h exp=%b/%b/%h", c, rid_a, rcar_a, rdata_a, m_id, m_carry, m_data);
        end
      end
      acc0 = g0; acc1 = g1;
      if (!m_busy) begin
        if (g0 || g1) begin
          m_busy  = 1;
          m_id    = g1;
          m_data  = g1 ? res(req1_data, req1_num) : res(req0_data, req0_num);
          m_carry = g1 ? req1_cin : req0_cin;
        end
      end else if (!m_in_resp) begin
        m_in_resp = 1;
      end else if (rsp_ready) begin
        m_busy = 0; m_in_resp = 0; m_pref = !m_id;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
